// File: rtl/ifetch_pkg.sv
// Shared types and sizing for the instruction fetch queue.
// Entry layout and pointer/count widths used by top and FIFO.
package ifetch_pkg;

  localparam int XLEN      = 64;
  localparam int ILEN      = 32;
  localparam int DEPTH     = 4;
  localparam int MAX_OUTST = 2;
  localparam int PW        = $clog2(DEPTH);
  localparam int CW        = PW + 1;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
    logic            misalign;
  } fetch_entry_t;

  function automatic logic is_misaligned(
    input logic [XLEN-1:0] a
  );
    return a[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/ifetch_queue_fifo.sv
// Fetch buffer: DEPTH-entry synchronous FIFO of fetch entries.
// Clear dominates push/pop in the same cycle.
module fetch_fifo
  import ifetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         push,
  input  logic         pop,
  input  fetch_entry_t wdata,
  output fetch_entry_t head,
  output logic [CW-1:0] count,
  output logic         empty,
  output logic         full
);

  fetch_entry_t  mem_q [DEPTH];
  fetch_entry_t  mem_d [DEPTH];
  logic [PW-1:0] rd_q, rd_d;
  logic [PW-1:0] wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_pop, do_push;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_comb begin
    mem_d = mem_q;
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (clear) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_q] = wdata;
        wr_d        = wr_q + 1'b1;
      end
      if (do_pop) rd_d = rd_q + 1'b1;
      cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  assign head  = mem_q[rd_q];
  assign count = cnt_q;

endmodule

// File: rtl/ifetch_queue.sv
// Fetch stage: credit-based imem request issue, in-order response
// tracking, flush drop counting, buffered hand-off to decode.
module ifetch_queue
  import ifetch_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc,
  output logic            pc_ready,
  input  logic            flush,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [ILEN-1:0] imem_resp_data,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [XLEN-1:0] if_pc,
  output logic [ILEN-1:0] if_instr,
  output logic            if_misalign
);

  localparam int AW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam int SW = CW + 1;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic            misalign;
  } addr_ent_t;

  addr_ent_t     aq_q [MAX_OUTST];
  addr_ent_t     aq_d [MAX_OUTST];
  logic [AW-1:0] aq_rd_q, aq_rd_d;
  logic [AW-1:0] aq_wr_q, aq_wr_d;
  logic [CW-1:0] outst_q, outst_d;
  logic [CW-1:0] drop_q, drop_d;

  fetch_entry_t  head, wdata;
  logic [CW-1:0] occ;
  logic          empty, full;
  logic          credit_ok, push, pop;

  function automatic logic [AW-1:0] aq_inc(input logic [AW-1:0] p);
    return (p == AW'(MAX_OUTST - 1)) ? '0 : p + 1'b1;
  endfunction

  // Slots for every in-flight response are reserved before issue
  assign credit_ok = ((SW'(occ) + SW'(outst_q)) < SW'(DEPTH))
                   && (outst_q < CW'(MAX_OUTST));
  assign imem_req_valid = credit_ok & ~flush & rst;
  assign pc_ready       = imem_req_valid & imem_req_ready;
  assign imem_req_addr  = pc;

  assign push = imem_resp_valid & (drop_q == '0) & ~flush;
  assign pop  = if_valid & if_ready & ~flush;

  assign wdata = '{pc:       aq_q[aq_rd_q].pc,
                   instr:    imem_resp_data,
                   misalign: aq_q[aq_rd_q].misalign};

  always_comb begin
    aq_d    = aq_q;
    aq_rd_d = aq_rd_q;
    aq_wr_d = aq_wr_q;
    drop_d  = drop_q;
    if (pc_ready) begin
      aq_d[aq_wr_q] = '{pc: pc, misalign: is_misaligned(pc)};
      aq_wr_d       = aq_inc(aq_wr_q);
    end
    if (imem_resp_valid) aq_rd_d = aq_inc(aq_rd_q);
    outst_d = outst_q + CW'(pc_ready) - CW'(imem_resp_valid);
    // Everything still in flight after this edge belongs to the old path
    if (flush)
      drop_d = outst_q - CW'(imem_resp_valid);
    else if (imem_resp_valid && drop_q != '0)
      drop_d = drop_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < MAX_OUTST; i++) aq_q[i] <= '0;
      aq_rd_q <= '0;
      aq_wr_q <= '0;
      outst_q <= '0;
      drop_q  <= '0;
    end else begin
      aq_q    <= aq_d;
      aq_rd_q <= aq_rd_d;
      aq_wr_q <= aq_wr_d;
      outst_q <= outst_d;
      drop_q  <= drop_d;
    end
  end

  fetch_fifo u_fifo (
    .clk   (clk),
    .rst_n (rst),
    .clear (flush),
    .push  (push),
    .pop   (pop),
    .wdata (wdata),
    .head  (head),
    .count (occ),
    .empty (empty),
    .full  (full)
  );

  assign if_valid    = ~empty;
  assign if_pc       = head.pc;
  assign if_instr    = head.instr;
  assign if_misalign = head.misalign;

  resp_needs_outst: assert property (
    @(posedge clk) disable iff (!rst)
    imem_resp_valid |-> (outst_q != '0));

  no_overflow: assert property (
    @(posedge clk) disable iff (!rst)
    push |-> (!full || pop));

endmodule

// File: tb/tb_ifetch_queue.sv
// Bench for ifetch_queue: queue-level reference model, in-order memory
// with programmable latency, directed scenarios with literal checks.
module tb_ifetch_queue;
  import ifetch_pkg::*;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [XLEN-1:0] pc;
  logic            pc_ready;
  logic            flush;
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_resp_valid;
  logic [ILEN-1:0] imem_resp_data;
  logic            if_valid;
  logic            if_ready;
  logic [XLEN-1:0] if_pc;
  logic [ILEN-1:0] if_instr;
  logic            if_misalign;

  ifetch_queue dut (
    .clk             (clk),
    .rst             (rst),
    .pc              (pc),
    .pc_ready        (pc_ready),
    .flush           (flush),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .if_valid        (if_valid),
    .if_ready        (if_ready),
    .if_pc           (if_pc),
    .if_instr        (if_instr),
    .if_misalign     (if_misalign)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [XLEN-1:0] pc;
    bit              live;
  } flight_t;

  typedef struct {
    logic [XLEN-1:0] addr;
    int              due;
  } mreq_t;

  fetch_entry_t    mq[$];
  flight_t         aq[$];
  mreq_t           pend[$];
  logic [XLEN-1:0] pcq[$];
  logic [XLEN-1:0] ret_pc[$];
  logic [XLEN-1:0] acc_pc[$];
  bit              ret_mis[$];

  int cyc, lat, checks, passes;
  int dut_out, max_out, first_acc, first_val;

  function automatic logic [ILEN-1:0] mem_of(input logic [XLEN-1:0] a);
    return a[ILEN-1:0] ^ 32'h1357_9bdf;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
  endtask

  task automatic model_reset();
    mq.delete();
    aq.delete();
    pend.delete();
    dut_out = 0;
  endtask

  // One cycle: drive, compare against model, advance model at the edge
  task automatic step();
    bit           erv, ev, popf;
    fetch_entry_t e;
    flight_t      h;
    imem_req_ready = (pcq.size() > 0);
    if (pcq.size() > 0) pc = pcq[0];
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = mem_of(pend[0].addr);
    end
    #1;
    erv = (mq.size() + aq.size() < DEPTH) && (aq.size() < MAX_OUTST) && !flush;
    ev  = mq.size() > 0;
    chk("req_valid", imem_req_valid, erv);
    chk("pc_ready", pc_ready, erv && imem_req_ready);
    if (erv) chk("req_addr", imem_req_addr, pc);
    chk("if_valid", if_valid, ev);
    if (ev) begin
      chk("if_pc", if_pc, mq[0].pc);
      chk("if_instr", if_instr, mq[0].instr);
      chk("if_misalign", if_misalign, mq[0].misalign);
    end
    if (if_valid && if_ready && !flush) begin
      ret_pc.push_back(if_pc);
      ret_mis.push_back(if_misalign);
      if (first_val < 0) first_val = cyc;
    end
    if (pc_ready) begin
      acc_pc.push_back(imem_req_addr);
      if (first_acc < 0) first_acc = cyc;
      if (pcq.size() > 0) void'(pcq.pop_front());
    end
    dut_out += int'(pc_ready) - int'(imem_resp_valid);
    if (dut_out > max_out) max_out = dut_out;
    popf = ev && if_ready && !flush;
    @(posedge clk);
    if (popf) void'(mq.pop_front());
    if (imem_resp_valid) begin
      h = aq.pop_front();
      void'(pend.pop_front());
      if (h.live && !flush) begin
        e.pc       = h.pc;
        e.instr    = imem_resp_data;
        e.misalign = (h.pc[1:0] != 2'b00);
        mq.push_back(e);
      end
    end
    if (flush) begin
      mq.delete();
      foreach (aq[i]) aq[i].live = 1'b0;
    end
    if (erv && imem_req_ready) begin
      aq.push_back('{pc, 1'b1});
      pend.push_back('{pc, cyc + lat});
    end
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    checks = 0; passes = 0; cyc = 0; lat = 1;
    dut_out = 0; max_out = 0; first_acc = -1; first_val = -1;
    pc = '0; flush = 1'b0; if_ready = 1'b1;
    imem_req_ready = 1'b1; imem_resp_valid = 1'b0; imem_resp_data = '0;

    // Reset state
    #1 rst = 1'b0;
    #1;
    chk("rst_req_valid", imem_req_valid, 0);
    chk("rst_pc_ready", pc_ready, 0);
    chk("rst_if_valid", if_valid, 0);
    chk("rst_if_pc", if_pc, 0);
    chk("rst_if_instr", if_instr, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    // 1: straight-line fetch, 1-cycle memory
    for (int i = 0; i < 3; i++) pcq.push_back(XLEN'(4 * i));
    repeat (8) step();
    chk("t1_count", ret_pc.size(), 3);
    for (int i = 0; i < 3; i++) chk("t1_order", ret_pc[i], 64'(4 * i));
    chk("t1_latency", first_val - first_acc, 2);

    // 2: decode stalled, buffer fills to DEPTH
    ret_pc.delete(); acc_pc.delete(); if_ready = 1'b0;
    for (int i = 0; i < 8; i++) pcq.push_back(XLEN'(64'h100 + 4 * i));
    repeat (10) step();
    chk("t2_accepts", acc_pc.size(), 4);
    if_ready = 1'b1;
    repeat (14) step();
    chk("t2_total", ret_pc.size(), 8);
    for (int i = 0; i < 8; i++) chk("t2_order", ret_pc[i], 64'(64'h100 + 4 * i));

    // 3: long memory latency, outstanding capped
    ret_pc.delete(); max_out = 0; lat = 5;
    for (int i = 0; i < 6; i++) pcq.push_back(XLEN'(64'h200 + 4 * i));
    repeat (40) step();
    chk("t3_max_out", max_out, 2);
    chk("t3_total", ret_pc.size(), 6);

    // 4: flush with 2 in flight and 2 buffered
    ret_pc.delete(); lat = 3; if_ready = 1'b0;
    for (int i = 0; i < 4; i++) pcq.push_back(XLEN'(64'h300 + 4 * i));
    repeat (6) step();
    chk("t4_buffered", if_valid, 1);
    flush = 1'b1;
    pcq.push_back(64'h400);
    step();
    flush = 1'b0; if_ready = 1'b1;
    #1;
    chk("t4_flush_ivalid", if_valid, 0);
    repeat (10) step();
    chk("t4_delivered", ret_pc.size(), 1);
    chk("t4_new_pc", ret_pc[0], 64'h400);

    // 5: misaligned PC
    ret_pc.delete(); ret_mis.delete(); lat = 1;
    pcq.push_back(64'h1002);
    repeat (5) step();
    chk("t5_pc", ret_pc[0], 64'h1002);
    chk("t5_misalign", ret_mis[0], 1);

    // 6: asynchronous reset mid-traffic
    lat = 2;
    for (int i = 0; i < 4; i++) pcq.push_back(XLEN'(64'h500 + 4 * i));
    repeat (3) step();
    #2 rst = 1'b0;
    imem_resp_valid = 1'b0;
    #1;
    chk("t6_req_valid", imem_req_valid, 0);
    chk("t6_pc_ready", pc_ready, 0);
    chk("t6_if_valid", if_valid, 0);
    chk("t6_if_pc", if_pc, 0);
    chk("t6_if_instr", if_instr, 0);
    chk("t6_if_misalign", if_misalign, 0);
    model_reset();
    pcq.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    acc_pc.delete(); ret_pc.delete();
    pcq.push_back(64'h600);
    repeat (6) step();
    chk("t6_first_addr", acc_pc[0], 64'h600);
    chk("t6_delivered", ret_pc.size(), 1);
    chk("t6_pc", ret_pc[0], 64'h600);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
